// File: rtl/alm_err_monitor.sv
// Error monitor for an approximate signed multiplier.
// Each accepted sample (a, b, z) is compared with the exact product a*b.
// The monitor then accumulates the relative error |a*b - z| / |a*b| as a
// fixed-point value, counts the samples and tracks the largest error distance.
module alm_err_monitor #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [2*WIDTH-1:0]   i_z,
  output logic [47:0]          o_sum_re,
  output logic [31:0]          o_count,
  output logic [2*WIDTH:0]     o_max_ed,
  output logic                 o_busy
);

  localparam int unsigned PW = 2 * WIDTH;     // product width
  localparam int unsigned EW = PW + 1;        // error-distance width
  localparam int unsigned NB = EW + FRAC_BITS; // dividend / quotient width
  localparam int unsigned CW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_ACC  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [PW-1:0]        z_q;
  logic [EW-1:0]        ed_q;
  logic [PW-1:0]        den_q;
  logic [NB-1:0]        shift_q;  // dividend bits shift out, quotient bits shift in
  logic [PW-1:0]        rem_q;
  logic [CW-1:0]        cnt_q;
  logic [47:0]          sum_q;
  logic [31:0]          count_q;
  logic [EW-1:0]        max_q;

  // CALC datapath: exact product, error distance and divisor
  logic signed [PW-1:0] a_ext, b_ext, exact;
  logic signed [EW-1:0] diff;
  logic [EW-1:0]        ed_calc;
  logic [PW-1:0]        den_calc;
  logic                 exact_zero;

  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign exact = a_ext * b_ext;
  // |exact| <= 2^(PW-2) and |z| <= 2^(PW-1), so the difference fits EW signed bits
  assign diff  = {exact[PW-1], exact} - {z_q[PW-1], z_q};
  assign ed_calc    = diff[EW-1] ? EW'(-diff) : diff;
  assign den_calc   = exact[PW-1] ? PW'(-exact) : exact;
  assign exact_zero = (exact == '0);

  // One restoring-division step
  logic [PW:0]   rem_sh;
  logic          q_bit;
  logic [PW-1:0] rem_nxt;

  // Restoring divider step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh  = {rem_q, shift_q[NB-1]};
    q_bit   = (rem_sh >= {1'b0, den_q});
    rem_nxt = q_bit ? PW'(rem_sh - {1'b0, den_q}) : rem_sh[PW-1:0];
  end

  // Accumulator next values with saturation
  logic [48:0]   sum_ext;
  logic [47:0]   sum_sat;
  logic [31:0]   count_sat;

  // Saturating accumulate of the finished quotient and sample count
  always_comb begin
    sum_ext   = {1'b0, sum_q} + 49'(shift_q);
    sum_sat   = sum_ext[48] ? '1 : sum_ext[47:0];
    count_sat = (count_q == '1) ? count_q : count_q + 32'd1;
  end

  // Next-state logic; clear aborts any sample in flight
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_valid) state_d = S_CALC;
        S_CALC:  state_d = exact_zero ? S_IDLE : S_DIV;
        S_DIV:   if (cnt_q == '0) state_d = S_ACC;
        S_ACC:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample capture and divider datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ed_q    <= '0;
      den_q   <= '0;
      shift_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid && !i_clear) begin
            a_q <= i_a;
            b_q <= i_b;
            z_q <= i_z;
          end
        end
        S_CALC: begin
          ed_q    <= ed_calc;
          den_q   <= den_calc;
          shift_q <= {ed_calc, {FRAC_BITS{1'b0}}};
          rem_q   <= '0;
          cnt_q   <= CW'(NB - 1);
        end
        S_DIV: begin
          shift_q <= {shift_q[NB-2:0], q_bit};
          rem_q   <= rem_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: touched only by reset, clear or the ACC state
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      sum_q   <= '0;
      count_q <= '0;
      max_q   <= '0;
    end else if (state_q == S_ACC) begin
      sum_q   <= sum_sat;
      count_q <= count_sat;
      if (ed_q > max_q) max_q <= ed_q;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_sum_re = sum_q;
  assign o_count  = count_q;
  assign o_max_ed = max_q;

endmodule

// File: doc/alm_err_monitor.md
ALM_ERR_MONITOR -- requirements
Module: alm_err_monitor

Interface
REQ-001 Parameter WIDTH, default 8, signed operand width of the multiplier under evaluation.
REQ-002 Parameter FRAC_BITS, default 16, fractional bits of each per-sample relative error.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_clear  input  1  synchronous accumulator clear / abort.
REQ-006 i_valid  input  1  sample valid.
REQ-007 o_ready  output  1  monitor can accept a sample.
REQ-008 i_a, i_b  input  WIDTH each  signed operands.
REQ-009 i_z  input  2*WIDTH  signed approximate product from the multiplier.
REQ-010 o_sum_re  output  48  unsigned sum of relative errors, FRAC_BITS fractional bits.
REQ-011 o_count  output  32  number of non-zero-exact samples accumulated.
REQ-012 o_max_ed  output  2*WIDTH+1  largest error distance seen.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, CALC, DIV, ACC; o_ready=1 only in IDLE.
REQ-015 Handshake i_valid&&o_ready in IDLE registers i_a, i_b, i_z and moves to CALC; i_valid without o_ready is ignored (no queueing).
REQ-016 CALC (1 cycle): exact = i_a*i_b as signed 2*WIDTH (fits, incl. -128*-128=16384); ED = |exact - z| in 2*WIDTH+1 bits unsigned; den = |exact|.
REQ-017 CALC with exact==0: sample discarded, no output changes, next state IDLE.
REQ-018 CALC with exact!=0: next state DIV.
REQ-019 DIV: restoring divider, one quotient bit per cycle, exactly 2*WIDTH+1+FRAC_BITS cycles (33 at defaults), q = floor((ED << FRAC_BITS) / den), no rounding.
REQ-020 ACC (1 cycle): o_sum_re += q saturating at 2^48-1; o_count += 1 saturating at 2^32-1; o_max_ed = max(o_max_ed, ED); next IDLE.
REQ-021 Latency at defaults: handshake cycle N, CALC N+1, DIV N+2..N+34, ACC N+35, updated outputs and o_ready=1 visible in cycle N+36.
REQ-022 Zero-product latency: handshake cycle N, o_ready=1 again in cycle N+2.
REQ-023 Outputs change only in ACC, on reset, or on clear.
REQ-024 i_clear in any state: o_sum_re, o_count, o_max_ed zeroed, in-flight sample discarded, FSM to IDLE next cycle.
REQ-025 i_clear together with i_valid in IDLE: clear wins, sample not captured.
REQ-026 i_valid held high continuously: one sample accepted per IDLE visit, no double capture.

Reset
REQ-027 i_rst high at a clock edge: FSM IDLE, o_sum_re=0, o_count=0, o_max_ed=0, o_busy=0, internal divider state cleared; o_ready=1 first cycle after i_rst deasserts.
REQ-028 i_rst asserted mid-DIV aborts the sample exactly as i_clear; i_rst takes priority over i_clear and i_valid.

Verification
REQ-029 a=3, b=5, z=15 -> ED=0, o_sum_re=0, o_count=1, o_max_ed=0, o_ready back exactly 36 cycles after handshake.
REQ-030 a=10, b=10, z=96 -> ED=4, q=2621, o_sum_re=2621, o_count=1, o_max_ed=4.
REQ-031 a=0, b=77, z=5 -> outputs unchanged, o_ready high 2 cycles after handshake.
REQ-032 a=-128, b=-128, z=-32768 -> exact=16384, ED=49152, q=196608, o_max_ed=49152.
REQ-033 Accept a=-1, b=1, z=0, assert i_clear during DIV -> next cycle all outputs 0, o_busy=0, o_ready=1; following sample accumulates from zero.
REQ-034 Exhaustive sweep (-128..127 squared) against a reference model of this block -> o_count=65025 and o_sum_re bit-exact to the model's sum of floor quotients.
